stim_sequencer: RTL and testbench

STIM_SEQUENCER -- requirements
Module: stim_sequencer

---
 rtl/stim_sequencer_pkg.sv | 23 ++
 rtl/stim_sequencer_lfsr16.sv | 37 +++
 rtl/stim_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_stim_sequencer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/stim_sequencer_pkg.sv
// Shared types and constants for the stimulus sequencer.
package stim_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RST  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic [1:0] MODE_ZERO   = 2'd0;
    localparam logic [1:0] MODE_ONE    = 2'd1;
    localparam logic [1:0] MODE_TOGGLE = 2'd2;
    localparam logic [1:0] MODE_LFSR   = 2'd3;

    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

    // One step of the right-shifting Fibonacci LFSR x^16+x^14+x^13+x^11+1
    function automatic logic [15:0] lfsr_step(input logic [15:0] q);
        return {q[0] ^ q[2] ^ q[3] ^ q[5], q[15:1]};
    endfunction

endpackage

// File: rtl/stim_sequencer_lfsr16.sv
// 16-bit Fibonacci LFSR with synchronous load and shift enable.
module lfsr16
    import stim_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] seed,
    input  logic        en,
    output logic [15:0] q
);

    logic [15:0] q_q;
    logic [15:0] q_d;

    // Load has priority over shifting
    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = seed;
        end else if (en) begin
            q_d = lfsr_step(q_q);
        end
    end

    // LFSR state register
    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= LFSR_DEFAULT_SEED;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/stim_sequencer.sv
// Stimulus sequencer: resets a datapath, then drives a/b with a selected pattern.
module stim_sequencer
    import stim_sequencer_pkg::*;
#(
    parameter int unsigned LEN_W      = 16,
    parameter int unsigned RST_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             pause,
    input  logic [1:0]       mode,
    input  logic [LEN_W-1:0] len,
    input  logic [15:0]      seed,
    output logic             dut_reset,
    output logic             dut_a,
    output logic             dut_b,
    output logic             busy,
    output logic             done,
    output logic [LEN_W-1:0] cycle_cnt
);

    localparam int unsigned RCNT_W   = 8;
    localparam logic [RCNT_W-1:0] RST_LAST = RCNT_W'(RST_CYCLES - 1);

    state_e             state_q, state_d;
    logic [1:0]         mode_q, mode_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [LEN_W-1:0]   cnt_inc;
    logic [RCNT_W-1:0]  rst_cnt_q, rst_cnt_d;
    logic               dut_reset_q, dut_reset_d;
    logic               dut_a_q, dut_a_d;
    logic               dut_b_q, dut_b_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               lfsr_load;
    logic               lfsr_en;
    logic [15:0]        lfsr_seed;
    logic [15:0]        lfsr_q;
    logic [1:0]         first_ab;
    logic [1:0]         next_ab;
    logic               lfsr_unused;

    lfsr16 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .load  (lfsr_load),
        .seed  (lfsr_seed),
        .en    (lfsr_en),
        .q     (lfsr_q)
    );

    // Upper LFSR bits only matter for feedback inside lfsr16
    assign lfsr_unused = ^lfsr_q[15:3];

    // Pattern values {a,b}: first RUN cycle, and the value following the current one
    always_comb begin
        first_ab = 2'b00;
        next_ab  = 2'b00;
        case (mode_q)
            MODE_ONE: begin
                first_ab = 2'b11;
                next_ab  = 2'b11;
            end
            MODE_TOGGLE: begin
                first_ab = 2'b10;
                next_ab  = {~dut_a_q, dut_a_q};
            end
            MODE_LFSR: begin
                // After one right shift, new bit0 = q[1] and new bit1 = q[2]
                first_ab = {lfsr_q[0], lfsr_q[1]};
                next_ab  = {lfsr_q[1], lfsr_q[2]};
            end
            default: begin
                first_ab = 2'b00;
                next_ab  = 2'b00;
            end
        endcase
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        rst_cnt_d = rst_cnt_q;
        dut_a_d   = 1'b0;
        dut_b_d   = 1'b0;
        lfsr_load = 1'b0;
        lfsr_en   = 1'b0;
        lfsr_seed = seed;
        cnt_inc   = cnt_q + LEN_W'(1);

        if ((mode == MODE_LFSR) && (seed == 16'h0000)) begin
            lfsr_seed = LFSR_DEFAULT_SEED;
        end

        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d   = RST;
                        mode_d    = mode;
                        len_d     = len;
                        cnt_d     = '0;
                        rst_cnt_d = '0;
                        lfsr_load = 1'b1;
                    end
                end
                RST: begin
                    if (rst_cnt_q == RST_LAST) begin
                        if (len_q == '0) begin
                            state_d = DONE;
                        end else begin
                            state_d            = RUN;
                            {dut_a_d, dut_b_d} = first_ab;
                        end
                    end else begin
                        rst_cnt_d = rst_cnt_q + RCNT_W'(1);
                    end
                end
                RUN: begin
                    if (pause) begin
                        dut_a_d = dut_a_q;
                        dut_b_d = dut_b_q;
                    end else begin
                        cnt_d   = cnt_inc;
                        lfsr_en = 1'b1;
                        if (cnt_inc == len_q) begin
                            state_d = DONE;
                        end else begin
                            {dut_a_d, dut_b_d} = next_ab;
                        end
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        dut_reset_d = (state_d == RST);
        busy_d      = (state_d == RST) || (state_d == RUN);
        done_d      = (state_d == DONE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            mode_q      <= MODE_ZERO;
            len_q       <= '0;
            cnt_q       <= '0;
            rst_cnt_q   <= '0;
            dut_reset_q <= 1'b0;
            dut_a_q     <= 1'b0;
            dut_b_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            rst_cnt_q   <= rst_cnt_d;
            dut_reset_q <= dut_reset_d;
            dut_a_q     <= dut_a_d;
            dut_b_q     <= dut_b_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign dut_reset = dut_reset_q;
    assign dut_a     = dut_a_q;
    assign dut_b     = dut_b_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign cycle_cnt = cnt_q;

endmodule

// File: tb/tb_stim_sequencer.sv
// Scoreboard bench for stim_sequencer: expected per-cycle output records are queued, a monitor compares.
module tb_stim_sequencer;
    import stim_sequencer_pkg::*;

    localparam int unsigned LW = 4;

    logic          clk = 1'b0;
    logic          reset, start, abort, pause;
    logic [1:0]    mode;
    logic [LW-1:0] len;
    logic [15:0]   seed;
    logic          dut_reset, dut_a, dut_b, busy, done;
    logic [LW-1:0] cycle_cnt;

    typedef struct packed {
        logic          rst;
        logic          a;
        logic          b;
        logic          busy;
        logic          done;
        logic [LW-1:0] cnt;
    } rec_t;

    rec_t exp_q[$];
    rec_t mon_got, mon_exp;
    int   checks = 0;
    int   passes = 0;
    bit   mon_en = 1'b0;

    stim_sequencer #(.LEN_W(LW), .RST_CYCLES(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .pause     (pause),
        .mode      (mode),
        .len       (len),
        .seed      (seed),
        .dut_reset (dut_reset),
        .dut_a     (dut_a),
        .dut_b     (dut_b),
        .busy      (busy),
        .done      (done),
        .cycle_cnt (cycle_cnt)
    );

    always #5 clk = ~clk;

    // Reference Fibonacci LFSR, taps 16,14,13,11 in right-shift form
    function automatic logic [15:0] lfsr_ref(input logic [15:0] v);
        logic fb;
        fb = v[0] ^ v[2] ^ v[3] ^ v[5];
        return {fb, v[15:1]};
    endfunction

    task automatic push(input logic r, input logic a, input logic b,
                        input logic bz, input logic d, input int c);
        rec_t e;
        e.rst  = r;
        e.a    = a;
        e.b    = b;
        e.busy = bz;
        e.done = d;
        e.cnt  = LW'(c);
        exp_q.push_back(e);
    endtask

    task automatic push_rst();
        repeat (4) push(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got == exp) passes++;
        else $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    endtask

    task automatic check_idle(input string name, input int exp_cnt);
        check({name, "_busy"},  int'(busy), 0);
        check({name, "_done"},  int'(done), 0);
        check({name, "_rst"},   int'(dut_reset), 0);
        check({name, "_ab"},    int'({dut_a, dut_b}), 0);
        check({name, "_cnt"},   int'(cycle_cnt), exp_cnt);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            tick(1);
            k++;
        end
        checks++;
        if (exp_q.size() == 0) passes++;
        else begin
            $display("FAIL %s_drain got=%0d records left exp=0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Monitor: any active output cycle consumes one expected record
    always @(negedge clk) begin
        if (mon_en && (busy || done || dut_reset || dut_a || dut_b)) begin
            mon_got = '{rst: dut_reset, a: dut_a, b: dut_b, busy: busy, done: done, cnt: cycle_cnt};
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_output got rst=%b a=%b b=%b busy=%b done=%b cnt=%0d exp=idle",
                         dut_reset, dut_a, dut_b, busy, done, cycle_cnt);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got === mon_exp) passes++;
                else $display("FAIL trace got rst=%b a=%b b=%b busy=%b done=%b cnt=%0d exp rst=%b a=%b b=%b busy=%b done=%b cnt=%0d",
                              mon_got.rst, mon_got.a, mon_got.b, mon_got.busy, mon_got.done, mon_got.cnt,
                              mon_exp.rst, mon_exp.a, mon_exp.b, mon_exp.busy, mon_exp.done, mon_exp.cnt);
            end
        end
    end

    initial begin
        logic [15:0] v;
        int          pcnt [11];

        reset = 1'b1; start = 1'b0; abort = 1'b0; pause = 1'b0;
        mode = MODE_ZERO; len = '0; seed = 16'h0000;
        tick(3);
        reset = 1'b0;
        mon_en = 1'b1;
        check_idle("reset", 0);

        // Toggle pattern len=5, with a start issued in the DONE cycle
        mode = MODE_TOGGLE; len = LW'(5);
        push_rst();
        push(0, 1, 0, 1, 0, 0);
        push(0, 0, 1, 1, 0, 1);
        push(0, 1, 0, 1, 0, 2);
        push(0, 0, 1, 1, 0, 3);
        push(0, 1, 0, 1, 0, 4);
        push(0, 0, 0, 0, 1, 5);
        pulse_start();
        tick(9);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_drain("toggle", 5);
        tick(4);
        check_idle("toggle_idle", 5);

        // len=0 goes RST->DONE; pause held throughout must be ignored
        mode = MODE_ONE; len = '0; pause = 1'b1;
        push_rst();
        push(0, 0, 0, 0, 1, 0);
        pulse_start();
        wait_drain("len0", 20);
        pause = 1'b0;
        tick(3);
        check_idle("len0_idle", 0);

        // LFSR with seed 0 -> default seed ACE1
        mode = MODE_LFSR; len = LW'(6); seed = 16'h0000;
        push_rst();
        v = 16'hACE1;
        for (int i = 0; i < 6; i++) begin
            push(0, v[0], v[1], 1, 0, i);
            v = lfsr_ref(v);
        end
        push(0, 0, 0, 0, 1, 6);
        pulse_start();
        wait_drain("lfsr0", 30);
        tick(2);

        // LFSR with seed 3: 0003, 8001, C000, 6000
        seed = 16'h0003; len = LW'(4);
        push_rst();
        push(0, 1, 1, 1, 0, 0);
        push(0, 1, 0, 1, 0, 1);
        push(0, 0, 0, 1, 0, 2);
        push(0, 0, 0, 1, 0, 3);
        push(0, 0, 0, 0, 1, 4);
        pulse_start();
        wait_drain("lfsr3", 30);
        tick(2);
        check_idle("lfsr3_idle", 4);

        // Pause for 3 cycles from the 3rd RUN cycle
        mode = MODE_ONE; len = LW'(8);
        pcnt = '{0, 1, 2, 2, 2, 2, 3, 4, 5, 6, 7};
        push_rst();
        foreach (pcnt[i]) push(0, 1, 1, 1, 0, pcnt[i]);
        push(0, 0, 0, 0, 1, 8);
        pulse_start();
        tick(6);
        pause = 1'b1;
        tick(3);
        pause = 1'b0;
        wait_drain("pause", 30);
        tick(2);
        check_idle("pause_idle", 8);

        // Abort in 2nd RUN cycle of len=10
        mode = MODE_ONE; len = LW'(10);
        push_rst();
        push(0, 1, 1, 1, 0, 0);
        push(0, 1, 1, 1, 0, 1);
        pulse_start();
        tick(5);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        check_idle("abort", 1);
        wait_drain("abort", 2);

        // abort and start together in IDLE: stay idle
        start = 1'b1; abort = 1'b1;
        tick(1);
        start = 1'b0; abort = 1'b0;
        tick(6);
        check_idle("abort_start", 1);

        // A subsequent run proceeds normally
        mode = MODE_ZERO; len = LW'(2);
        push_rst();
        push(0, 0, 0, 1, 0, 0);
        push(0, 0, 0, 1, 0, 1);
        push(0, 0, 0, 0, 1, 2);
        pulse_start();
        wait_drain("after_abort", 20);
        tick(3);
        check_idle("after_abort_idle", 2);

        // Reset during RST
        mode = MODE_TOGGLE; len = LW'(5);
        repeat (3) push(1, 0, 0, 1, 0, 0);
        pulse_start();
        tick(2);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check_idle("reset_mid", 0);
        wait_drain("reset_mid", 2);
        tick(6);
        check_idle("reset_mid_quiet", 0);

        // Maximum length 2^LW-1 completes without wrap
        mode = MODE_TOGGLE; len = LW'(15);
        push_rst();
        for (int i = 0; i < 15; i++) push(0, (i % 2) == 0, (i % 2) != 0, 1, 0, i);
        push(0, 0, 0, 0, 1, 15);
        pulse_start();
        wait_drain("maxlen", 40);
        tick(3);
        check_idle("maxlen_idle", 15);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
